mbinit_sb_msg_arbiter: RTL and testbench

- Sequences the single sideband transmit port shared between the TX-side and RX-side sub-FSMs of an MBINIT state (REPAIRCLK, REPAIRVAL, ...).
- Each requester owns a one-entry holding slot. The arbiter grants one slot and presents its message to the sideband as a one-cycle valid pulse.
- It tracks sideband busy through to completion, acknowledges the winning requester, and flags a sideband that never accepts the message.

---
 rtl/mbinit_sb_msg_arbiter.sv | 144 ++++++++++++++
 tb/tb_mbinit_sb_msg_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mbinit_sb_msg_arbiter.sv
// rtl/mbinit_sb_msg_arbiter.sv - two-slot sideband message arbiter for MBINIT sub-FSMs
module mbinit_sb_msg_arbiter #(
  parameter int SB_MSG_Width = 4,
  parameter int ARB_MODE     = 0,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_tx_req,
  input  logic [SB_MSG_Width-1:0] i_tx_msg,
  output logic                    o_tx_ready,
  output logic                    o_tx_ack,
  input  logic                    i_rx_req,
  input  logic [SB_MSG_Width-1:0] i_rx_msg,
  output logic                    o_rx_ready,
  output logic                    o_rx_ack,
  input  logic                    i_sb_busy,
  output logic [SB_MSG_Width-1:0] o_encoded_sb_msg,
  output logic                    o_msg_valid,
  output logic                    o_grant_rx,
  output logic                    o_timeout_err,
  output logic                    o_protocol_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    tx_full_q, rx_full_q;
  logic [SB_MSG_Width-1:0] tx_msg_q, rx_msg_q;
  logic                    grant_rx_q, grant_rx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    timeout_q, protocol_q;
  logic                    pick_rx;
  logic                    ack_fire, timeout_fire;
  logic                    tx_clear, rx_clear;
  logic                    run;

  // Flush (i_en low) behaves exactly like reset.
  assign run = i_en & ~i_rst;

  // Winner choice when leaving IDLE; a lone full slot always wins.
  always_comb begin
    pick_rx = rx_full_q;
    if (tx_full_q && rx_full_q) begin
      pick_rx = (ARB_MODE == 0) ? 1'b1 : ~grant_rx_q;
    end
  end

  // Next-state logic; ack and timeout are decided in the cycle they happen.
  always_comb begin
    state_d      = state_q;
    grant_rx_d   = grant_rx_q;
    cnt_d        = cnt_q;
    ack_fire     = 1'b0;
    timeout_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if ((tx_full_q || rx_full_q) && !i_sb_busy) begin
          state_d    = SEND;
          grant_rx_d = pick_rx;
        end
      end
      SEND: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
      end
      WAIT_BUSY: begin
        if (i_sb_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout_fire = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!i_sb_busy) begin
          ack_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_clear = (ack_fire | timeout_fire) & ~grant_rx_q;
  assign rx_clear = (ack_fire | timeout_fire) &  grant_rx_q;

  // FSM, grant pointer and timeout counter registers.
  always_ff @(posedge i_clk) begin
    if (!run) begin
      state_q    <= IDLE;
      grant_rx_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_rx_q <= grant_rx_d;
      cnt_q      <= cnt_d;
    end
  end

  // Holding slots and sticky errors; a request into a full slot is dropped.
  always_ff @(posedge i_clk) begin
    if (!run) begin
      tx_full_q  <= 1'b0;
      rx_full_q  <= 1'b0;
      tx_msg_q   <= '0;
      rx_msg_q   <= '0;
      timeout_q  <= 1'b0;
      protocol_q <= 1'b0;
    end else begin
      if (i_tx_req && !tx_full_q) begin
        tx_full_q <= 1'b1;
        tx_msg_q  <= i_tx_msg;
      end else if (tx_clear) begin
        tx_full_q <= 1'b0;
      end
      if (i_rx_req && !rx_full_q) begin
        rx_full_q <= 1'b1;
        rx_msg_q  <= i_rx_msg;
      end else if (rx_clear) begin
        rx_full_q <= 1'b0;
      end
      if ((i_tx_req && tx_full_q) || (i_rx_req && rx_full_q)) protocol_q <= 1'b1;
      if (timeout_fire) timeout_q <= 1'b1;
    end
  end

  assign o_msg_valid      = run & (state_q == SEND);
  assign o_encoded_sb_msg = (run && state_q != IDLE) ? (grant_rx_q ? rx_msg_q : tx_msg_q) : '0;
  assign o_grant_rx       = run & grant_rx_q;
  assign o_tx_ack         = run & ack_fire & ~grant_rx_q;
  assign o_rx_ack         = run & ack_fire &  grant_rx_q;
  assign o_timeout_err    = run & (timeout_q | timeout_fire);
  assign o_protocol_err   = run & protocol_q;
  assign o_tx_ready       = i_en & (i_rst | ~tx_full_q);
  assign o_rx_ready       = i_en & (i_rst | ~rx_full_q);

endmodule

// File: tb/tb_mbinit_sb_msg_arbiter.sv
// tb/tb_mbinit_sb_msg_arbiter.sv - self-checking bench for mbinit_sb_msg_arbiter
module tb_mbinit_sb_msg_arbiter;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst, en, tx_req, rx_req, busy;
  logic [3:0] tx_msg, rx_msg;
  logic [3:0] enc[2];
  logic       valid[2], txrdy[2], rxrdy[2], txack[2], rxack[2], grant[2], terr[2], perr[2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mbinit_sb_msg_arbiter #(.SB_MSG_Width(4), .ARB_MODE(0), .TIMEOUT_CYC(TO)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_tx_req(tx_req), .i_tx_msg(tx_msg), .o_tx_ready(txrdy[0]), .o_tx_ack(txack[0]),
    .i_rx_req(rx_req), .i_rx_msg(rx_msg), .o_rx_ready(rxrdy[0]), .o_rx_ack(rxack[0]),
    .i_sb_busy(busy), .o_encoded_sb_msg(enc[0]), .o_msg_valid(valid[0]),
    .o_grant_rx(grant[0]), .o_timeout_err(terr[0]), .o_protocol_err(perr[0]));

  mbinit_sb_msg_arbiter #(.SB_MSG_Width(4), .ARB_MODE(1), .TIMEOUT_CYC(TO)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_tx_req(tx_req), .i_tx_msg(tx_msg), .o_tx_ready(txrdy[1]), .o_tx_ack(txack[1]),
    .i_rx_req(rx_req), .i_rx_msg(rx_msg), .o_rx_ready(rxrdy[1]), .o_rx_ack(rxack[1]),
    .i_sb_busy(busy), .o_encoded_sb_msg(enc[1]), .o_msg_valid(valid[1]),
    .o_grant_rx(grant[1]), .o_timeout_err(terr[1]), .o_protocol_err(perr[1]));

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Transaction-level model: each slot, the in-flight message and its age since the send strobe.
  bit         m_full[2][2];
  logic [3:0] m_msg[2][2];
  bit         m_act[2], m_saw[2], m_win[2], m_last[2], m_te[2], m_pe[2];
  int         m_age[2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit run, f_ack, f_to, done, dside, f0, f1;
      bit rq[2];
      logic [3:0] mg[2];
      run   = en && !rst;
      f_ack = run && m_act[k] && m_saw[k] && !busy;
      f_to  = run && m_act[k] && !m_saw[k] && m_age[k] == TO && !busy;
      chk("msg_valid", k, 32'(valid[k]), 32'(run && m_act[k] && m_age[k] == 0));
      chk("enc_msg",   k, 32'(enc[k]),   (run && m_act[k]) ? 32'(m_msg[k][m_win[k]]) : 32'd0);
      chk("grant_rx",  k, 32'(grant[k]), 32'(run && m_last[k]));
      chk("tx_ack",    k, 32'(txack[k]), 32'(f_ack && !m_win[k]));
      chk("rx_ack",    k, 32'(rxack[k]), 32'(f_ack && m_win[k]));
      chk("timeout",   k, 32'(terr[k]),  32'(run && (m_te[k] || f_to)));
      chk("protocol",  k, 32'(perr[k]),  32'(run && m_pe[k]));
      chk("tx_ready",  k, 32'(txrdy[k]), 32'(en && (rst || !m_full[k][0])));
      chk("rx_ready",  k, 32'(rxrdy[k]), 32'(en && (rst || !m_full[k][1])));
      if (!run) begin
        m_full[k][0] = 0; m_full[k][1] = 0;
        m_act[k] = 0; m_saw[k] = 0; m_age[k] = 0; m_win[k] = 0;
        m_last[k] = 0; m_te[k] = 0; m_pe[k] = 0;
      end else begin
        f0 = m_full[k][0]; f1 = m_full[k][1];
        done = f_ack || f_to; dside = m_win[k];
        rq[0] = tx_req; rq[1] = rx_req; mg[0] = tx_msg; mg[1] = rx_msg;
        for (int s = 0; s < 2; s++) begin
          if (rq[s] && !m_full[k][s]) begin
            m_full[k][s] = 1; m_msg[k][s] = mg[s];
          end else begin
            if (rq[s]) m_pe[k] = 1;
            if (done && int'(dside) == s) m_full[k][s] = 0;
          end
        end
        if (f_to) m_te[k] = 1;
        if (m_act[k]) begin
          if (m_age[k] == 0) m_age[k] = 1;
          else if (!m_saw[k]) begin
            if (busy) m_saw[k] = 1;
            else if (f_to) m_act[k] = 0;
            else m_age[k]++;
          end else if (!busy) m_act[k] = 0;
        end else if ((f0 || f1) && !busy) begin
          m_win[k]  = (f0 && f1) ? ((k == 1) ? !m_last[k] : 1'b1) : f1;
          m_last[k] = m_win[k];
          m_act[k] = 1; m_age[k] = 0; m_saw[k] = 0;
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
    tx_req = 0; rx_req = 0;
  endtask

  task automatic settle(input int n);
    busy = 0;
    repeat (n) nxt();
  endtask

  initial begin
    rst = 1; en = 1; tx_req = 0; rx_req = 0; busy = 0; tx_msg = 0; rx_msg = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_ready", 0, 32'(txrdy[0]), 32'd1);
    chk("rst_grant", 1, 32'(grant[1]), 32'd0);

    // single TX with busy 3..5
    nxt(); tx_req = 1; tx_msg = 4'h3;
    nxt(); @(negedge clk); chk("a_ready_full", 0, 32'(txrdy[0]), 32'd0);
    nxt(); @(negedge clk); chk("a_valid", 0, 32'(valid[0]), 32'd1); chk("a_msg", 0, 32'(enc[0]), 32'h3);
    nxt(); busy = 1; nxt(); nxt();
    nxt(); busy = 0; @(negedge clk); chk("a_ack", 0, 32'(txack[0]), 32'd1);
    nxt(); @(negedge clk); chk("a_ready", 0, 32'(txrdy[0]), 32'd1); chk("a_msg0", 0, 32'(enc[0]), 32'h0);

    // simultaneous, both after a TX grant: RX first, TX two cycles after the RX ack
    settle(3);
    tx_req = 1; tx_msg = 4'h2; rx_req = 1; rx_msg = 4'h9;
    nxt(); nxt(); @(negedge clk); chk("b_first", 1, 32'(enc[1]), 32'h9); chk("b_first", 0, 32'(enc[0]), 32'h9);
    nxt(); busy = 1;
    nxt(); busy = 0; @(negedge clk); chk("b_rx_ack", 0, 32'(rxack[0]), 32'd1);
    nxt(); nxt(); @(negedge clk); chk("b_second_v", 0, 32'(valid[0]), 32'd1); chk("b_second", 0, 32'(enc[0]), 32'h2);
    nxt(); busy = 1; nxt(); busy = 0;

    // RX alone, then a tie: mode 0 picks RX, mode 1 picks TX
    settle(3);
    rx_req = 1; rx_msg = 4'h5;
    nxt(); nxt(); nxt(); busy = 1; nxt(); busy = 0;
    nxt(); tx_req = 1; tx_msg = 4'h2; rx_req = 1; rx_msg = 4'h9;
    nxt(); nxt(); @(negedge clk);
    chk("c_mode0", 0, 32'(enc[0]), 32'h9); chk("c_mode1", 1, 32'(enc[1]), 32'h2);
    chk("c_grant1", 1, 32'(grant[1]), 32'd0);
    nxt(); busy = 1;
    nxt(); settle(14);

    // flush pulse, then timeout
    en = 0; nxt(); en = 1;
    nxt(); tx_req = 1; tx_msg = 4'h7;
    repeat (5) nxt();
    @(negedge clk); chk("t_not_yet", 0, 32'(terr[0]), 32'd0);
    nxt(); @(negedge clk); chk("t_err", 0, 32'(terr[0]), 32'd1); chk("t_noack", 0, 32'(txack[0]), 32'd0);
    nxt(); @(negedge clk); chk("t_ready", 0, 32'(txrdy[0]), 32'd1); chk("t_sticky", 0, 32'(terr[0]), 32'd1);

    // overflow
    nxt(); rx_req = 1; rx_msg = 4'hA;
    nxt(); rx_req = 1; rx_msg = 4'hB;
    nxt(); @(negedge clk); chk("o_perr", 0, 32'(perr[0]), 32'd1); chk("o_msg", 0, 32'(enc[0]), 32'hA);
    settle(6);

    // flush during WAIT_DONE
    rx_req = 1; rx_msg = 4'h4;
    nxt(); nxt(); nxt(); busy = 1;
    nxt(); en = 0; @(negedge clk); chk("f_noack", 0, 32'(rxack[0]), 32'd0);
    nxt(); en = 1; busy = 0; @(negedge clk);
    chk("f_msg0", 0, 32'(enc[0]), 32'h0); chk("f_terr", 0, 32'(terr[0]), 32'd0);
    chk("f_perr", 0, 32'(perr[0]), 32'd0); chk("f_ready", 0, 32'(rxrdy[0]), 32'd1);

    // sideband busy when the request arrives
    nxt(); busy = 1; tx_req = 1; tx_msg = 4'hC;
    repeat (10) nxt();
    busy = 0; @(negedge clk); chk("w_wait", 0, 32'(valid[0]), 32'd0);
    nxt(); @(negedge clk); chk("w_valid", 0, 32'(valid[0]), 32'd1); chk("w_msg", 0, 32'(enc[0]), 32'hC);
    settle(8);

    // randomized traffic
    repeat (4000) begin
      nxt();
      tx_req = ($urandom_range(0, 3) == 0);
      rx_req = ($urandom_range(0, 3) == 0);
      tx_msg = 4'($urandom);
      rx_msg = 4'($urandom);
      if ($urandom_range(0, 2) == 0) busy = ~busy;
      en  = ($urandom_range(0, 149) != 0);
      rst = ($urandom_range(0, 299) == 0);
    end
    nxt(); rst = 0; en = 1;
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
